zxspi_target: RTL and testbench
===============================

# zxspi_target

SPI target (slave) endpoint answering the Z80-side SPI master peripheral: it receives bytes shifted out on MOSI, returns bytes on MISO, and hands received data to local logic through a valid/ack interface. It oversamples the SPI pins with the system clock, so all state lives in the `clk` domain. It sits behind an SPI chip-select line, typically in a bench model or a companion device on the same board.

## Interface
- `CPOL`, 0: SPI clock idle level. Must match the master's polarity setting. CPHA is fixed at 0.
- `clk` in 1: system clock. `spi_clk` must be ≤ `clk`/8.
- `reset_L` in 1: asynchronous, active-low reset.
- `spi_clk` in 1: SPI clock from the master. Asynchronous.
- `mosi` in 1: serial data from the master.
- `spi_cs_L` in 1: chip select, active low.
- `miso` out 1: serial data to the master.
- `miso_oe` out 1: MISO output enable, 1 while the target is selected.
- `tx_data` in 8: byte to return on the next transfer.
- `tx_load` in 1: one-cycle strobe that writes `tx_data` into the TX holding register.
- `tx_ready` out 1: TX holding register is empty.
- `rx_data` out 8: oldest received byte.
- `rx_valid` out 1: `rx_data` holds an unread byte.
- `rx_ack` in 1: pops `rx_data`. Ignored when `rx_valid`=0.
- `overrun` out 1: sticky flag, set when a received byte is dropped.
- `ovr_clr` in 1: clears `overrun`.
- `busy` out 1: a transfer is in progress (synchronized CS is asserted).

## Operation
- `spi_clk`, `mosi` and `spi_cs_L` each pass through a 2-flop synchronizer. The `spi_clk` synchronizer output feeds a third flop used for edge detection.
- Leading edge = idle→active transition of `spi_clk`. Trailing edge = the return to idle.
- Data is MSB first, 8-bit bytes.
- CS assert (synchronized falling edge):
  - If `tx_ready`=0, the TX shift register loads the holding register and `tx_ready` rises. Otherwise it loads 0xFF.
  - `miso` = shift[7]. Bit counter = 0.
- Leading edge: shift synchronized `mosi` into the RX shift register (LSB in). Bit counter +1.
- On the 8th leading edge, the byte completes:
  - The assembled byte is pushed to RX storage.
  - The counter wraps to 0.
  - The TX shift register reloads (holding register or 0xFF, same rule as CS assert) on the following trailing edge.
- Trailing edge, not after a completed byte: TX shift left (fill with 1), `miso` = new shift[7].
- CS deassert mid-byte: the partial byte is discarded, the counter returns to 0, and nothing is pushed. Edges on `spi_clk` are ignored while CS is deasserted.
- `tx_load` while `tx_ready`=0 is ignored; the holding register keeps its content.
- RX storage, single-register build:
  - A push while `rx_valid`=1 and no `rx_ack` drops the new byte and sets `overrun`. The old byte is kept.
  - A push and `rx_ack` in the same cycle stores the new byte; `rx_valid` stays 1 and there is no overrun.
- `ovr_clr` and an overrun event in the same cycle: `overrun` stays 1 (set wins).
- `miso_oe` = `busy` = synchronized CS active.
- `miso` = 1 when not selected.

## Timing
- Reset values: `miso`=1, `miso_oe`=0, `tx_ready`=1, `rx_data`=0x00, `rx_valid`=0, `overrun`=0, `busy`=0. Shift registers, holding register and counter are all 0.
- A raw pin edge is seen by the logic after 3 `clk` edges: 2 sync flops plus the edge flop.
- `rx_valid`/`rx_data` update on the `clk` edge following detection of the 8th leading edge, i.e. at most 4 `clk` after the raw pin edge.
- `miso` changes at most 4 `clk` after a raw trailing edge or CS assert. This sets the `clk` ≥ 8×`spi_clk` requirement.
- `tx_ready` rises in the same cycle the holding register is copied to the TX shift register.
- `rx_ack` takes effect at the next `clk` edge.
- `reset_L` low mid-transfer aborts the transfer immediately to the reset values.

## Configuration
- `ZXSPI_TARGET_RXFIFO_EN` defined:
  - RX storage is a 4-entry FIFO (2-bit pointers, 3-bit count). `rx_data` shows the head entry. `rx_valid` = count≠0.
  - A push at count=4 without `rx_ack` drops the byte and sets `overrun`.
  - A push and a pop in the same cycle at count=4 is accepted.
- Not defined: single holding register, with the rules given under Operation.

## Test plan
- CPOL=0. CS low, master shifts 0xA5, `tx_data`=0x3C preloaded → `rx_data`=0xA5 with `rx_valid`=1; master reads 0x3C; `tx_ready`=1 after CS assert.
- No `tx_load` before the transfer, master shifts 0x00 → master reads 0xFF, `rx_data`=0x00.
- Two back-to-back bytes 0x11, 0x22 without `rx_ack`:
  - Single-register build: `rx_data`=0x11, `overrun`=1.
  - FIFO build: both bytes are held; successive `rx_ack`s pop 0x11 then 0x22, `overrun`=0.
- CS deasserted after 5 bits, then a full byte 0x81 → only 0x81 is received, `rx_valid` pulses once.
- CPOL=1. Two-byte transfer 0xF0, 0x0F with `tx_load`s of 0x12 and 0x34 → `rx_data` 0xF0 then 0x0F; master reads 0x12, 0x34.
- `reset_L` asserted after 4 bits → all outputs return to their reset values; a following 0x5A transfer is received correctly.

Source files
------------

// File: rtl/zxspi_target.sv
// rtl/zxspi_target.sv - SPI target endpoint, oversampled in the clk domain, CPHA=0
//
// Purpose: receives MSB-first bytes on mosi, returns bytes on miso, and hands
//   received bytes to local logic through rx_valid/rx_ack.
// Parameter: CPOL - idle level of spi_clk.
// Optional build macro: ZXSPI_TARGET_RXFIFO_EN - 4-entry RX FIFO instead of
//   a single RX holding register.
// Ports:
//   clk, reset_L          system clock, asynchronous active-low reset
//   spi_clk, mosi         SPI clock and data from the master (asynchronous)
//   spi_cs_L              SPI chip select, active low (asynchronous)
//   miso, miso_oe         SPI data to the master and its output enable
//   tx_data, tx_load      byte for the next transfer and its write strobe
//   tx_ready              TX holding register empty
//   rx_data, rx_valid     oldest received byte and its valid flag
//   rx_ack                pops rx_data
//   overrun, ovr_clr      sticky dropped-byte flag and its clear
//   busy                  synchronized chip select active
`timescale 1ns/1ps
module zxspi_target #(
   parameter logic CPOL = 1'b0
) (
   input  logic       clk,
   input  logic       reset_L,
   input  logic       spi_clk,
   input  logic       mosi,
   input  logic       spi_cs_L,
   output logic       miso,
   output logic       miso_oe,
   input  logic [7:0] tx_data,
   input  logic       tx_load,
   output logic       tx_ready,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   input  logic       rx_ack,
   output logic       overrun,
   input  logic       ovr_clr,
   output logic       busy
);

   // [0] first sync flop, [1] second sync flop, [2] edge-detect flop
   logic [2:0] sclk_sync;
   logic [1:0] mosi_sync;
   logic [2:0] cs_sync;

   logic [7:0] tx_shift;
   logic [7:0] tx_hold;
   logic       tx_full;
   logic [7:0] rx_shift;
   logic [2:0] bit_cnt;
   logic       reload_pending;

   logic       sclk_now, sclk_prev;
   logic       selected, cs_fall, cs_rise;
   logic       lead, trail;
   logic       push, drop, copy;
   logic [7:0] rx_byte;
   logic [7:0] tx_next;

   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
         sclk_sync <= {3{CPOL}};
         mosi_sync <= 2'b00;
         cs_sync   <= 3'b111;
      end else begin
         sclk_sync <= {sclk_sync[1:0], spi_clk};
         mosi_sync <= {mosi_sync[0], mosi};
         cs_sync   <= {cs_sync[1:0], spi_cs_L};
      end
   end

   // Normalize spi_clk so that 1 means "active" regardless of CPOL.
   assign sclk_now  = sclk_sync[1] ^ CPOL;
   assign sclk_prev = sclk_sync[2] ^ CPOL;
   assign selected  = ~cs_sync[1];
   assign cs_fall   = ~cs_sync[1] &  cs_sync[2];
   assign cs_rise   =  cs_sync[1] & ~cs_sync[2];
   assign lead      = selected &  sclk_now & ~sclk_prev;
   assign trail     = selected & ~sclk_now &  sclk_prev;

   // mosi_sync[1] has the same latency as sclk_sync[1], so it is the bit
   // the master presented before this leading edge.
   assign rx_byte = {rx_shift[6:0], mosi_sync[1]};
   assign push    = lead & (bit_cnt == 3'd7);
   assign tx_next = tx_full ? tx_hold : 8'hFF;
   assign copy    = cs_fall | (trail & reload_pending);

   assign miso     = selected ? tx_shift[7] : 1'b1;
   assign miso_oe  = selected;
   assign busy     = selected;
   assign tx_ready = ~tx_full;

   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
         tx_shift       <= 8'h00;
         rx_shift       <= 8'h00;
         bit_cnt        <= 3'd0;
         reload_pending <= 1'b0;
      end else if (cs_fall) begin
         tx_shift       <= tx_next;
         bit_cnt        <= 3'd0;
         reload_pending <= 1'b0;
      end else if (cs_rise) begin
         bit_cnt        <= 3'd0;
         reload_pending <= 1'b0;
      end else begin
         if (lead) begin
            rx_shift <= rx_byte;
            bit_cnt  <= bit_cnt + 3'd1;   // wraps 7 -> 0 at byte end
            if (bit_cnt == 3'd7)
               reload_pending <= 1'b1;
         end
         // The trailing edge right after a completed byte presents the
         // next byte's MSB instead of shifting.
         if (trail) begin
            if (reload_pending) begin
               tx_shift       <= tx_next;
               reload_pending <= 1'b0;
            end else begin
               tx_shift <= {tx_shift[6:0], 1'b1};
            end
         end
      end
   end

   // A load and a copy never meet: load needs the register empty, copy
   // only clears it when full.
   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
         tx_hold <= 8'h00;
         tx_full <= 1'b0;
      end else if (copy && tx_full) begin
         tx_full <= 1'b0;
      end else if (tx_load && !tx_full) begin
         tx_hold <= tx_data;
         tx_full <= 1'b1;
      end
   end

`ifdef ZXSPI_TARGET_RXFIFO_EN
   logic [7:0] fifo_mem [4];
   logic [1:0] wr_ptr, rd_ptr;
   logic [2:0] count;
   logic       pop, accept;

   assign pop      = rx_ack & (count != 3'd0);
   assign accept   = push & ((count != 3'd4) | pop);
   assign drop     = push & ~accept;
   assign rx_data  = fifo_mem[rd_ptr];
   assign rx_valid = (count != 3'd0);

   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
         for (int i = 0; i < 4; i++)
            fifo_mem[i] <= 8'h00;
         wr_ptr <= 2'd0;
         rd_ptr <= 2'd0;
         count  <= 3'd0;
      end else begin
         if (accept) begin
            fifo_mem[wr_ptr] <= rx_byte;
            wr_ptr           <= wr_ptr + 2'd1;
         end
         if (pop)
            rd_ptr <= rd_ptr + 2'd1;
         count <= count + {2'b00, accept} - {2'b00, pop};
      end
   end
`else
   logic [7:0] rx_reg;
   logic       rx_full;

   assign drop     = push & rx_full & ~rx_ack;
   assign rx_data  = rx_reg;
   assign rx_valid = rx_full;

   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
         rx_reg  <= 8'h00;
         rx_full <= 1'b0;
      end else if (push && (!rx_full || rx_ack)) begin
         rx_reg  <= rx_byte;
         rx_full <= 1'b1;
      end else if (rx_ack) begin
         rx_full <= 1'b0;
      end
   end
`endif

   // Set wins over clear.
   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L)
         overrun <= 1'b0;
      else if (drop)
         overrun <= 1'b1;
      else if (ovr_clr)
         overrun <= 1'b0;
   end

endmodule

// File: tb/tb_zxspi_target.sv
// tb/tb_zxspi_target.sv - directed-vector bench for zxspi_target (CPOL=0 and CPOL=1 instances)
`timescale 1ns/1ps
module tb_zxspi_target;

   localparam int CLK  = 10;
   localparam int HALF = 50;

   logic clk = 1'b0;
   logic reset_L = 1'b0;
   logic mosi = 1'b0;
   logic [7:0] tx_data = 8'h00;
   logic ovr_clr = 1'b0;

   logic sclk0 = 1'b0, cs0 = 1'b1, tx_load0 = 1'b0, rx_ack0 = 1'b0;
   logic miso0, miso_oe0, tx_ready0, rx_valid0, overrun0, busy0;
   logic [7:0] rx_data0;

   logic sclk1 = 1'b1, cs1 = 1'b1, tx_load1 = 1'b0, rx_ack1 = 1'b0;
   logic miso1, miso_oe1, tx_ready1, rx_valid1, overrun1, busy1;
   logic [7:0] rx_data1;

   int n_vec = 0;
   int n_miss = 0;
   int pulses0 = 0;
   logic rv_prev0 = 1'b0;

   always #(CLK/2) clk = ~clk;

   zxspi_target #(.CPOL(1'b0)) dut0 (
      .clk(clk), .reset_L(reset_L), .spi_clk(sclk0), .mosi(mosi), .spi_cs_L(cs0),
      .miso(miso0), .miso_oe(miso_oe0), .tx_data(tx_data), .tx_load(tx_load0),
      .tx_ready(tx_ready0), .rx_data(rx_data0), .rx_valid(rx_valid0), .rx_ack(rx_ack0),
      .overrun(overrun0), .ovr_clr(ovr_clr), .busy(busy0));

   zxspi_target #(.CPOL(1'b1)) dut1 (
      .clk(clk), .reset_L(reset_L), .spi_clk(sclk1), .mosi(mosi), .spi_cs_L(cs1),
      .miso(miso1), .miso_oe(miso_oe1), .tx_data(tx_data), .tx_load(tx_load1),
      .tx_ready(tx_ready1), .rx_data(rx_data1), .rx_valid(rx_valid1), .rx_ack(rx_ack1),
      .overrun(overrun1), .ovr_clr(ovr_clr), .busy(busy1));

   always @(posedge clk) begin
      rv_prev0 <= rx_valid0;
      if (rx_valid0 && !rv_prev0)
         pulses0 <= pulses0 + 1;
   end

   task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic set_clk(input int sel, input logic act);
      if (sel == 0) sclk0 = act;
      else          sclk1 = ~act;
   endtask

   task automatic set_cs(input int sel, input logic v);
      if (sel == 0) cs0 = v;
      else          cs1 = v;
   endtask

   task automatic begin_xfer(input int sel);
      set_cs(sel, 1'b0);
      #HALF;
   endtask

   task automatic end_xfer(input int sel);
      #HALF;
      set_cs(sel, 1'b1);
      #(8*CLK);
   endtask

   // CPHA=0 master: data out before the leading edge, miso sampled on it.
   task automatic spi_bits(input int sel, input logic [7:0] b, input int nbits,
                           output logic [7:0] r);
      r = 8'h00;
      for (int i = 0; i < nbits; i++) begin
         mosi = b[7-i];
         #HALF;
         set_clk(sel, 1'b1);
         r = {r[6:0], (sel == 0) ? miso0 : miso1};
         #HALF;
         set_clk(sel, 1'b0);
      end
   endtask

   task automatic load0(input logic [7:0] d);
      @(negedge clk); tx_data = d; tx_load0 = 1'b1;
      @(negedge clk); tx_load0 = 1'b0;
   endtask

   task automatic load1(input logic [7:0] d);
      @(negedge clk); tx_data = d; tx_load1 = 1'b1;
      @(negedge clk); tx_load1 = 1'b0;
   endtask

   task automatic ack0;
      @(negedge clk); rx_ack0 = 1'b1;
      @(negedge clk); rx_ack0 = 1'b0;
   endtask

   task automatic ack1;
      @(negedge clk); rx_ack1 = 1'b1;
      @(negedge clk); rx_ack1 = 1'b0;
   endtask

   task automatic check_reset_state(input string tag);
      check_eq({tag, " miso"},     miso0,     1'b1);
      check_eq({tag, " miso_oe"},  miso_oe0,  1'b0);
      check_eq({tag, " tx_ready"}, tx_ready0, 1'b1);
      check_eq({tag, " rx_data"},  rx_data0,  8'h00);
      check_eq({tag, " rx_valid"}, rx_valid0, 1'b0);
      check_eq({tag, " overrun"},  overrun0,  1'b0);
      check_eq({tag, " busy"},     busy0,     1'b0);
      check_eq({tag, " miso1"},    miso1,     1'b1);
      check_eq({tag, " rx_valid1"}, rx_valid1, 1'b0);
   endtask

   logic [7:0] r, r2;
   int p0;

   initial begin
      repeat (3) @(negedge clk);
      check_reset_state("reset");
      reset_L = 1'b1;
      repeat (3) @(negedge clk);
      check_reset_state("post_reset");

      // 0xA5 in, preloaded 0x3C out
      load0(8'h3C);
      check_eq("load_tx_ready", tx_ready0, 1'b0);
      begin_xfer(0);
      check_eq("cs_busy", busy0, 1'b1);
      check_eq("cs_miso_oe", miso_oe0, 1'b1);
      check_eq("cs_tx_ready", tx_ready0, 1'b1);
      spi_bits(0, 8'hA5, 8, r);
      end_xfer(0);
      check_eq("a5_miso_read", r, 8'h3C);
      check_eq("a5_rx_valid", rx_valid0, 1'b1);
      check_eq("a5_rx_data", rx_data0, 8'hA5);
      check_eq("idle_busy", busy0, 1'b0);
      check_eq("idle_miso", miso0, 1'b1);
      ack0;
      check_eq("a5_ack_valid", rx_valid0, 1'b0);

      // no load: target answers 0xFF
      begin_xfer(0);
      spi_bits(0, 8'h00, 8, r);
      end_xfer(0);
      check_eq("00_miso_read", r, 8'hFF);
      check_eq("00_rx_data", rx_data0, 8'h00);
      check_eq("00_rx_valid", rx_valid0, 1'b1);
      ack0;

      // second load while full is ignored; back-to-back 0x11, 0x22 without ack
      load0(8'h55);
      load0(8'h66);
      check_eq("ign_tx_ready", tx_ready0, 1'b0);
      begin_xfer(0);
      spi_bits(0, 8'h11, 8, r);
      spi_bits(0, 8'h22, 8, r2);
      end_xfer(0);
      check_eq("b2b_read1", r, 8'h55);
      check_eq("b2b_read2", r2, 8'hFF);
      check_eq("b2b_rx_data", rx_data0, 8'h11);
`ifdef ZXSPI_TARGET_RXFIFO_EN
      check_eq("b2b_overrun", overrun0, 1'b0);
      ack0;
      check_eq("b2b_pop_valid", rx_valid0, 1'b1);
      check_eq("b2b_pop_data", rx_data0, 8'h22);
      ack0;
      check_eq("b2b_empty", rx_valid0, 1'b0);
`else
      check_eq("b2b_overrun", overrun0, 1'b1);
      ack0;
      check_eq("b2b_ack_valid", rx_valid0, 1'b0);
      check_eq("b2b_overrun_sticky", overrun0, 1'b1);
`endif
      @(negedge clk); ovr_clr = 1'b1;
      @(negedge clk); ovr_clr = 1'b0;
      check_eq("ovr_clr", overrun0, 1'b0);

      // CS deasserted after 5 bits, then 0x81
      p0 = pulses0;
      begin_xfer(0);
      spi_bits(0, 8'hFF, 5, r);
      end_xfer(0);
      check_eq("abort_rx_valid", rx_valid0, 1'b0);
      begin_xfer(0);
      spi_bits(0, 8'h81, 8, r);
      end_xfer(0);
      check_eq("abort_rx_data", rx_data0, 8'h81);
      check_eq("abort_pulses", pulses0 - p0, 16'd1);
      ack0;

      // CPOL=1: 0xF0, 0x0F with loads 0x12, 0x34
      load1(8'h12);
      begin_xfer(1);
      check_eq("c1_tx_ready", tx_ready1, 1'b1);
      load1(8'h34);
      spi_bits(1, 8'hF0, 8, r);
      check_eq("c1_rx1_valid", rx_valid1, 1'b1);
      check_eq("c1_rx1_data", rx_data1, 8'hF0);
      ack1;
      spi_bits(1, 8'h0F, 8, r2);
      end_xfer(1);
      check_eq("c1_read1", r, 8'h12);
      check_eq("c1_read2", r2, 8'h34);
      check_eq("c1_rx2_data", rx_data1, 8'h0F);
      check_eq("c1_overrun", overrun1, 1'b0);
      ack1;

      // reset after 4 bits, then 0x5A
      begin_xfer(0);
      spi_bits(0, 8'h5A, 4, r);
      reset_L = 1'b0;
      #1;
      check_reset_state("midreset");
      set_cs(0, 1'b1);
      #(CLK-1);
      reset_L = 1'b1;
      #(4*CLK);
      check_reset_state("after_midreset");
      begin_xfer(0);
      spi_bits(0, 8'h5A, 8, r);
      end_xfer(0);
      check_eq("5a_rx_data", rx_data0, 8'h5A);
      check_eq("5a_rx_valid", rx_valid0, 1'b1);
      check_eq("5a_miso_read", r, 8'hFF);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
